// File: rtl/fa_1bit.sv
// One-bit full adder cell.
// Used as the ripple-chain element of fa_4bit.
module fa_1bit (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    logic p;

    // Propagate, sum and carry-out of a single bit
    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (ci & p);
    end

endmodule

// File: rtl/fa_4bit.sv
// 4-bit ripple-carry adder built from fa_1bit cells.
// REG_OUT=1 registers {c,S}; REG_OUT=0 is purely combinational.
module fa_4bit #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic c,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic ci
);

    localparam int W = 4;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic [W:0]   carry;
    logic [W:0]   res;

    assign a        = {a3, a2, a1, a0};
    assign b        = {b3, b2, b1, b0};
    assign carry[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa_1bit u_fa (
            .s  (sum[i]),
            .co (carry[i+1]),
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [W:0] q;

        // Capture the ripple result each edge; reset wins over capture
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else begin
                q <= {carry[W], sum};
            end
        end

        assign res = q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst;
        assign res = {carry[W], sum};
    end

    assign {c, s3, s2, s1, s0} = res;

endmodule

// File: tb/tb_fa_4bit.sv
// Scoreboard bench for fa_4bit, registered and combinational builds.
// Expected sums come from plain integer addition of A, B and ci.
module tb_fa_4bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a0, a1, a2, a3, b0, b1, b2, b3, ci;
    logic rs0, rs1, rs2, rs3, rc;
    logic cs0, cs1, cs2, cs3, cc;

    int vectors = 0;
    int errors  = 0;

    logic [4:0] exp_q[$];
    logic [4:0] cexp_q[$];
    logic [8:0] seed_vec[10];
    event       comb_chk;

    always #5 clk = ~clk;

    fa_4bit #(.REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst(rst),
        .s0(rs0), .s1(rs1), .s2(rs2), .s3(rs3), .c(rc),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .ci(ci)
    );

    fa_4bit #(.REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rst),
        .s0(cs0), .s1(cs1), .s2(cs2), .s3(cs3), .c(cc),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .ci(ci)
    );

    function automatic logic [4:0] model(input int av, input int bv,
                                         input int cv);
        int total;
        total = av + bv + cv;
        return total[4:0];
    endfunction

    task automatic drive(input logic [3:0] av, input logic [3:0] bv,
                         input logic cv);
        {a3, a2, a1, a0} = av;
        {b3, b2, b1, b0} = bv;
        ci = cv;
    endtask

    // Registered build: set operands at negedge, push the expected
    // result, then scramble inputs mid-cycle to test holding.
    task automatic apply(input logic [3:0] av, input logic [3:0] bv,
                         input logic cv, input logic r);
        @(negedge clk);
        drive(av, bv, cv);
        rst = r;
        if (r) exp_q.push_back(5'd0);
        else   exp_q.push_back(model(int'(av), int'(bv), int'(cv)));
        @(posedge clk);
        #2;
        drive(4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic apply_vec(input logic [8:0] v, input logic r);
        apply({v[4], v[5], v[6], v[7]}, {v[0], v[1], v[2], v[3]},
              v[8], r);
    endtask

    // Registered monitor: check just after the edge and again late
    // in the cycle, after the inputs were scrambled.
    initial begin
        logic [4:0] e;
        logic [4:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {rc, rs3, rs2, rs1, rs0};
                vectors++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL reg_capture got=%b exp=%b t=%0t",
                             got, e, $time);
                end
                #3;
                got = {rc, rs3, rs2, rs1, rs0};
                vectors++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL reg_hold got=%b exp=%b t=%0t",
                             got, e, $time);
                end
            end
        end
    end

    // Combinational monitor
    initial begin
        logic [4:0] e;
        logic [4:0] got;
        forever begin
            @(comb_chk);
            if (cexp_q.size() > 0) begin
                e = cexp_q.pop_front();
                got = {cc, cs3, cs2, cs1, cs0};
                vectors++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL comb_result got=%b exp=%b t=%0t",
                             got, e, $time);
                end
            end
        end
    end

    initial begin
        integer seed;
        integer rv;
        seed = 1919;
        for (int i = 0; i < 10; i++) begin
            rv = $random(seed);
            seed_vec[i] = rv[8:0];
        end
        drive(4'd0, 4'd0, 1'b0);

        apply(4'hA, 4'h5, 1'b1, 1'b1);
        apply(4'h3, 4'hC, 1'b0, 1'b1);
        apply(4'd0, 4'd0, 1'b0, 1'b0);
        apply(4'b0101, 4'b0011, 1'b0, 1'b0);
        apply(4'b1111, 4'b0000, 1'b1, 1'b0);
        apply(4'b1111, 4'b1111, 1'b1, 1'b0);
        apply(4'b1010, 4'b0110, 1'b1, 1'b1);
        apply(4'b0001, 4'b0001, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) apply_vec(seed_vec[i], 1'b0);

        for (int i = 0; i < 20; i++) begin
            apply(4'($urandom), 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge clk);
        #5;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reg_drain left=%0d exp=0", exp_q.size());
        end

        // Combinational build, no clock dependence
        for (int i = 0; i < 10; i++) begin
            logic [8:0] v;
            logic [3:0] av;
            logic [3:0] bv;
            v  = seed_vec[i];
            av = {v[4], v[5], v[6], v[7]};
            bv = {v[0], v[1], v[2], v[3]};
            drive(av, bv, v[8]);
            cexp_q.push_back(model(int'(av), int'(bv), int'(v[8])));
            #1;
            ->comb_chk;
            #1;
        end
        drive(4'hF, 4'hF, 1'b1);
        cexp_q.push_back(5'd31);
        #1;
        ->comb_chk;
        #1;
        drive(4'd0, 4'd0, 1'b0);
        cexp_q.push_back(5'd0);
        #1;
        ->comb_chk;
        #1;
        vectors++;
        if (cexp_q.size() != 0) begin
            errors++;
            $display("FAIL comb_drain left=%0d exp=0", cexp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
